// File: rtl/matrix_ctrl_pkg.sv
// Shared types and width helpers for the LED matrix scan sequencer.
// Holds the scan state encoding and the command classification.
package matrix_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_CMD       = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_HOLD      = 3'd5,
    S_FRAME_END = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CMD_FIRST = 2'd0,
    CMD_NEXT  = 2'd1,
    CMD_DATA  = 2'd2
  } cmd_kind_t;

  // Counter/address width that never collapses to zero bits for a count of 1.
  function automatic int min1_clog2(input int n);
    return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
  endfunction

  function automatic cmd_kind_t cmd_kind(input logic first_col, input logic first_word);
    cmd_kind_t kind;
    if (!first_word) begin
      kind = CMD_DATA;
    end else if (first_col) begin
      kind = CMD_FIRST;
    end else begin
      kind = CMD_NEXT;
    end
    return kind;
  endfunction

endpackage

// File: rtl/scan_hold_timer.sv
// Loadable down-counter timing how long a column stays lit.
// done is registered and is high whenever the count is zero.
module scan_hold_timer
  import matrix_ctrl_pkg::*;
#(
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_value,
  input  logic              count_en,
  output logic              done
);

  localparam logic [HOLD_W-1:0] CNT_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1'b1);

  logic [HOLD_W-1:0] cnt_r;
  logic [HOLD_W-1:0] cnt_s;
  logic              done_r;

  // Next count: load wins, otherwise count down to zero and stop.
  always_comb begin
    cnt_s = cnt_r;
    if (load) begin
      cnt_s = load_value;
    end else if (count_en && (cnt_r != CNT_ZERO)) begin
      cnt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Count and zero flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= CNT_ZERO;
      done_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_s;
      done_r <= (cnt_s == CNT_ZERO);
    end
  end

  assign done = done_r;

endmodule

// File: rtl/matrix_scan_controller.sv
// Frame sequencer for output_module: fetches each SPI word from the frame
// buffer, issues the matching column/data command and holds each column lit.
module matrix_scan_controller
  import matrix_ctrl_pkg::*;
#(
  parameter int COLUMNS          = 16,
  parameter int WORDS_PER_COLUMN = 4,
  parameter int HOLD_W           = 16,
  parameter int ADDR_W           = min1_clog2(COLUMNS * WORDS_PER_COLUMN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_valid,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              cfg_extra_bit,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              start_first_column,
  output logic              start_next_column,
  output logic              next_data,
  output logic              extra_bit,
  input  logic              tx_finish,
  output logic              busy,
  output logic              frame_done
);

  localparam int COL_W  = min1_clog2(COLUMNS);
  localparam int WORD_W = min1_clog2(WORDS_PER_COLUMN);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLUMNS - 32'sd1);
  localparam logic [COL_W-1:0]  COL_ZERO  = {COL_W{1'b0}};
  localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1'b1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_COLUMN - 32'sd1);
  localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};
  localparam logic [WORD_W-1:0] WORD_ONE  = WORD_W'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

  state_t            state_r, state_s;
  logic [COL_W-1:0]  col_r, col_s;
  logic [WORD_W-1:0] word_r, word_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [HOLD_W-1:0] hold_cfg_r, hold_cfg_s;
  logic              extra_r, extra_s;
  logic              busy_r, busy_s;
  logic              rd_en_r, rd_en_s;
  logic              first_r, first_s;
  logic              next_col_r, next_col_s;
  logic              data_r, data_s;
  logic              done_r, done_s;
  logic              load_s;
  logic              hold_done_s;
  cmd_kind_t         kind_s;

  scan_hold_timer #(
    .HOLD_W(HOLD_W)
  ) u_hold_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_value(hold_cfg_r),
    .count_en  (state_r == S_HOLD),
    .done      (hold_done_s)
  );

  // Scan sequencing; every output is computed one cycle ahead and registered.
  always_comb begin
    state_s    = state_r;
    col_s      = col_r;
    word_s     = word_r;
    addr_s     = addr_r;
    hold_cfg_s = hold_cfg_r;
    extra_s    = extra_r;
    busy_s     = busy_r;
    rd_en_s    = 1'b0;
    first_s    = 1'b0;
    next_col_s = 1'b0;
    data_s     = 1'b0;
    done_s     = 1'b0;
    load_s     = 1'b0;
    kind_s     = cmd_kind(col_r == COL_ZERO, word_r == WORD_ZERO);
    case (state_r)
      S_IDLE: begin
        if (enable && frame_valid && tx_finish) begin
          state_s    = S_FETCH;
          col_s      = COL_ZERO;
          word_s     = WORD_ZERO;
          addr_s     = ADDR_ZERO;
          hold_cfg_s = cfg_hold;
          extra_s    = cfg_extra_bit;
          busy_s     = 1'b1;
          rd_en_s    = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        state_s = S_CMD;
        case (kind_s)
          CMD_FIRST: first_s    = 1'b1;
          CMD_NEXT:  next_col_s = 1'b1;
          CMD_DATA:  data_s     = 1'b1;
          default:   data_s     = 1'b0;
        endcase
      end
      S_CMD: begin
        state_s = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_finish) begin
          state_s = S_WAIT_DONE;
        end else begin
          state_s = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        if (tx_finish) begin
          if (word_r != WORD_LAST) begin
            word_s  = word_r + WORD_ONE;
            addr_s  = addr_r + ADDR_ONE;
            rd_en_s = 1'b1;
            state_s = S_FETCH;
          end else begin
            word_s  = WORD_ZERO;
            load_s  = 1'b1;
            state_s = S_HOLD;
          end
        end else begin
          state_s = S_WAIT_DONE;
        end
      end
      S_HOLD: begin
        if (hold_done_s) begin
          if (col_r != COL_LAST) begin
            col_s   = col_r + COL_ONE;
            addr_s  = addr_r + ADDR_ONE;
            rd_en_s = 1'b1;
            state_s = S_FETCH;
          end else begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = S_FRAME_END;
          end
        end else begin
          state_s = S_HOLD;
        end
      end
      S_FRAME_END: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      col_r      <= COL_ZERO;
      word_r     <= WORD_ZERO;
      addr_r     <= ADDR_ZERO;
      hold_cfg_r <= {HOLD_W{1'b0}};
      extra_r    <= 1'b0;
      busy_r     <= 1'b0;
      rd_en_r    <= 1'b0;
      first_r    <= 1'b0;
      next_col_r <= 1'b0;
      data_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      col_r      <= col_s;
      word_r     <= word_s;
      addr_r     <= addr_s;
      hold_cfg_r <= hold_cfg_s;
      extra_r    <= extra_s;
      busy_r     <= busy_s;
      rd_en_r    <= rd_en_s;
      first_r    <= first_s;
      next_col_r <= next_col_s;
      data_r     <= data_s;
      done_r     <= done_s;
    end
  end

  assign rd_en              = rd_en_r;
  assign rd_addr            = addr_r;
  assign start_first_column = first_r;
  assign start_next_column  = next_col_r;
  assign next_data          = data_r;
  assign extra_bit          = extra_r;
  assign busy               = busy_r;
  assign frame_done         = done_r;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: a procedural frame model predicts every
// output each cycle, and directed scenarios pin the model with literal checks.
module tb_matrix_scan_controller;

  localparam int C        = 2;
  localparam int W        = 2;
  localparam int HW       = 16;
  localparam int AW       = 2;
  localparam int BUSY_LEN = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          frame_valid = 1'b0;
  logic [HW-1:0] cfg_hold = '0;
  logic          cfg_extra_bit = 1'b0;
  logic          tx_finish = 1'b1;
  logic          rd_en, start_first_column, start_next_column, next_data;
  logic          extra_bit, busy, frame_done;
  logic [AW-1:0] rd_addr;

  matrix_scan_controller #(
    .COLUMNS(C), .WORDS_PER_COLUMN(W), .HOLD_W(HW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_valid(frame_valid),
    .cfg_hold(cfg_hold), .cfg_extra_bit(cfg_extra_bit),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .start_first_column(start_first_column), .start_next_column(start_next_column),
    .next_data(next_data), .extra_bit(extra_bit), .tx_finish(tx_finish),
    .busy(busy), .frame_done(frame_done)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output_module stand-in: goes busy for BUSY_LEN cycles on any command
  initial begin
    int rem;
    rem = 0;
    forever begin
      @(posedge clk); #2;
      if (start_first_column || start_next_column || next_data) begin
        tx_finish = 1'b0;
        rem = BUSY_LEN - 1;
      end else if (rem > 0) begin
        rem--;
      end else begin
        tx_finish = 1'b1;
      end
    end
  end

  // ---------------- reference model: the frame as a procedure ----------------
  logic          exp_rd_en = 1'b0, exp_first = 1'b0, exp_next = 1'b0, exp_data = 1'b0;
  logic          exp_extra = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  int            exp_addr = 0;
  bit            aborted = 1'b0;

  task automatic tick();
    @(posedge clk);
    if (rst) aborted = 1'b1;
  endtask

  task automatic model_clear();
    exp_rd_en = 1'b0; exp_first = 1'b0; exp_next = 1'b0; exp_data = 1'b0;
    exp_extra = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_addr = 0;
    aborted = 1'b0;
  endtask

  task automatic run_frame();
    int hold;
    hold = int'(cfg_hold);
    exp_extra = cfg_extra_bit;
    exp_busy = 1'b1;
    for (int c = 0; c < C; c++) begin
      for (int w = 0; w < W; w++) begin
        exp_rd_en = 1'b1;
        exp_addr = c * W + w;
        tick(); if (aborted) return;
        exp_rd_en = 1'b0;
        exp_first = (c == 0 && w == 0);
        exp_next  = (c > 0 && w == 0);
        exp_data  = (w > 0);
        tick(); if (aborted) return;
        exp_first = 1'b0; exp_next = 1'b0; exp_data = 1'b0;
        do begin tick(); if (aborted) return; end while (tx_finish);
        do begin tick(); if (aborted) return; end while (!tx_finish);
        if (w == W - 1) begin
          for (int h = 0; h <= hold; h++) begin
            tick(); if (aborted) return;
          end
        end
      end
    end
    exp_done = 1'b1;
    exp_busy = 1'b0;
    tick(); if (aborted) return;
    exp_done = 1'b0;
  endtask

  initial begin
    forever begin
      tick();
      if (aborted) begin
        model_clear();
      end else if (enable && frame_valid && tx_finish) begin
        run_frame();
        if (aborted) model_clear();
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    string name;
    int    act;
    int    exp_v;
  } chk_t;

  chk_t chk_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   addr_q[$], fetch_q[$], cmd_q[$], cmdcyc_q[$], done_q[$], rise_q[$];
  logic prev_tx = 1'b1;

  task automatic cmp(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push(input string name, input int act, input int exp_v);
    chk_q.push_back('{name: name, act: act, exp_v: exp_v});
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  // Per-cycle comparison against the model, event logging, literal checks.
  always @(negedge clk) begin
    chk_t ck;
    cmp("rd_en",      int'(rd_en),              rst ? 0 : int'(exp_rd_en));
    cmp("rd_addr",    int'(rd_addr),            rst ? 0 : exp_addr);
    cmp("start_first", int'(start_first_column), rst ? 0 : int'(exp_first));
    cmp("start_next", int'(start_next_column),  rst ? 0 : int'(exp_next));
    cmp("next_data",  int'(next_data),          rst ? 0 : int'(exp_data));
    cmp("extra_bit",  int'(extra_bit),          rst ? 0 : int'(exp_extra));
    cmp("busy",       int'(busy),               rst ? 0 : int'(exp_busy));
    cmp("frame_done", int'(frame_done),         rst ? 0 : int'(exp_done));
    if (rd_en) begin addr_q.push_back(int'(rd_addr)); fetch_q.push_back(cyc); end
    if (start_first_column) begin cmd_q.push_back(1); cmdcyc_q.push_back(cyc); end
    if (start_next_column)  begin cmd_q.push_back(2); cmdcyc_q.push_back(cyc); end
    if (next_data)          begin cmd_q.push_back(3); cmdcyc_q.push_back(cyc); end
    if (frame_done) done_q.push_back(cyc);
    if (tx_finish && !prev_tx) rise_q.push_back(cyc);
    prev_tx <= tx_finish;
    while (chk_q.size() > 0) begin
      ck = chk_q.pop_front();
      cmp(ck.name, ck.act, ck.exp_v);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_done(input int limit);
    int start, n;
    start = done_q.size();
    n = 0;
    while (done_q.size() == start && n < limit) begin step(1); n++; end
    push("wait_frame_done", (done_q.size() > start) ? 1 : 0, 1);
  endtask

  task automatic wait_cmd(input int limit);
    int start, n;
    start = cmd_q.size();
    n = 0;
    while (cmd_q.size() == start && n < limit) begin step(1); n++; end
    push("wait_command", (cmd_q.size() > start) ? 1 : 0, 1);
  endtask

  initial begin
    int a0, k0, d0, r0, a1, k1;
    int exp_cmd [4];
    exp_cmd[0] = 1; exp_cmd[1] = 3; exp_cmd[2] = 2; exp_cmd[3] = 3;

    step(3);
    push("reset_busy", int'(busy), 0);
    push("reset_rd_en", int'(rd_en), 0);
    rst = 1'b0;
    step(2);

    // frame 1: hold 0, basic ordering
    a0 = addr_q.size(); k0 = cmd_q.size(); d0 = done_q.size();
    cfg_hold = 16'd0; cfg_extra_bit = 1'b1; enable = 1'b1; frame_valid = 1'b1;
    wait_done(400);
    enable = 1'b0;
    step(8);
    push("f1_fetch_count", addr_q.size() - a0, 4);
    for (int i = 0; i < 4; i++) begin
      push("f1_rd_addr", qat(addr_q, a0 + i), i);
      push("f1_cmd_order", qat(cmd_q, k0 + i), exp_cmd[i]);
    end
    push("f1_done_count", done_q.size() - d0, 1);

    // frame 2: hold 10, config and enable change right after the first command
    a0 = addr_q.size(); k0 = cmd_q.size(); d0 = done_q.size(); r0 = rise_q.size();
    cfg_hold = 16'd10; cfg_extra_bit = 1'b0; enable = 1'b1;
    wait_cmd(100);
    cfg_hold = 16'd3; cfg_extra_bit = 1'b1; enable = 1'b0;
    push("f2_extra_latched", int'(extra_bit), 0);
    wait_done(400);
    push("f2_extra_held", int'(extra_bit), 0);
    // hold 10 leaves 11 cycles strictly between the tx_finish rise and the next event
    push("f2_col_gap", qat(fetch_q, a0 + 2) - qat(rise_q, r0 + 1) - 1, 11);
    push("f2_done_gap", qat(done_q, d0) - qat(rise_q, r0 + 3) - 1, 11);
    step(5);

    // frames 3+4 back-to-back with the config written during frame 2
    a0 = addr_q.size(); k0 = cmd_q.size(); d0 = done_q.size(); r0 = rise_q.size();
    enable = 1'b1;
    wait_done(400);
    wait_done(400);
    enable = 1'b0;
    step(8);
    push("b2b_first_kind", qat(cmd_q, k0 + 4), 1);
    push("b2b_start_latency", qat(cmdcyc_q, k0 + 4) - qat(done_q, d0), 3);
    push("b2b_addr_restart", qat(addr_q, a0 + 4), 0);
    push("b2b_hold3_gap", qat(fetch_q, a0 + 2) - qat(rise_q, r0 + 1) - 1, 4);
    push("b2b_extra", int'(extra_bit), 1);
    push("b2b_done_count", done_q.size() - d0, 2);

    // frame 5: enable and frame_valid dropped mid-frame
    a0 = addr_q.size(); k0 = cmd_q.size(); d0 = done_q.size();
    enable = 1'b1; frame_valid = 1'b1;
    wait_cmd(100);
    enable = 1'b0; frame_valid = 1'b0;
    wait_done(400);
    step(30);
    push("drop_done_count", done_q.size() - d0, 1);
    push("drop_cmd_count", cmd_q.size() - k0, 4);
    push("drop_fetch_count", addr_q.size() - a0, 4);
    push("drop_busy_idle", int'(busy), 0);

    // reset while waiting for tx_finish
    d0 = done_q.size();
    frame_valid = 1'b1; enable = 1'b1;
    wait_cmd(100);
    step(1);
    rst = 1'b1; enable = 1'b0;
    #1;
    push("rst_rd_en", int'(rd_en), 0);
    push("rst_rd_addr", int'(rd_addr), 0);
    push("rst_cmds", int'(start_first_column) + int'(start_next_column) + int'(next_data), 0);
    push("rst_busy", int'(busy), 0);
    push("rst_extra", int'(extra_bit), 0);
    push("rst_frame_done", int'(frame_done), 0);
    step(2);
    rst = 1'b0;
    step(2);
    a1 = addr_q.size(); k1 = cmd_q.size();
    step(20);
    push("post_rst_no_cmd", cmd_q.size() - k1, 0);
    push("post_rst_no_fetch", addr_q.size() - a1, 0);
    push("post_rst_no_done", done_q.size() - d0, 0);
    enable = 1'b1;
    wait_done(400);
    enable = 1'b0;
    push("post_rst_first_kind", qat(cmd_q, k1), 1);
    push("post_rst_addr0", qat(addr_q, a1), 0);
    push("post_rst_done", done_q.size() - d0, 1);

    step(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_scan_controller.md
Name: matrix_scan_controller

Overview:
Frame-level sequencer for output_module. It walks all columns of the LED matrix. For each column it issues one column-select command, carrying the first SPI word, then the remaining SPI words as next_data commands. It fetches each word from the frame buffer just before sending it, applies a configurable per-column display hold, and signals frame completion to the buffer manager.

Parameters:
COLUMNS, 16, number of matrix columns scanned per frame (>=1)
WORDS_PER_COLUMN, 4, SPI words per column, i.e. chained modules (>=1)
HOLD_W, 16, width of the per-column hold counter
ADDR_W, $clog2(COLUMNS*WORDS_PER_COLUMN), frame buffer read address width (derived; >=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  scanning allowed; sampled only in IDLE
frame_valid  in  1  frame buffer holds a displayable frame (level)
cfg_hold  in  HOLD_W  extra cycles each column stays lit after its last word; latched at frame start
cfg_extra_bit  in  1  value driven on extra_bit; latched at frame start
rd_en  out  1  frame buffer read strobe; synchronous RAM, data valid 1 cycle later and held until the next rd_en
rd_addr  out  ADDR_W  read address = col*WORDS_PER_COLUMN + word
start_first_column  out  1  one-cycle command to output_module
start_next_column  out  1  one-cycle command to output_module
next_data  out  1  one-cycle command to output_module
extra_bit  out  1  latched cfg_extra_bit
tx_finish  in  1  output_module idle flag; 1 when idle
busy  out  1  high from frame start until frame_done
frame_done  out  1  one-cycle pulse after the last column's hold expires

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Reset forces every output to 0, all counters to 0 and the state to IDLE. Reset mid-transfer abandons the frame with no frame_done.
- States: IDLE, FETCH, CMD, WAIT_BUSY, WAIT_DONE, HOLD, FRAME_END.
- IDLE: if enable && frame_valid && tx_finish, then latch cfg_hold and cfg_extra_bit, clear col/word, and go to FETCH; busy goes to 1.
- FETCH: rd_en=1 and rd_addr driven for one cycle; next state is CMD.
- CMD: exactly one command pulses for one cycle, then go to WAIT_BUSY.
  - word==0 and col==0: start_first_column.
  - word==0 and col>0: start_next_column.
  - word>0: next_data.
  - Buffer data must be valid in this cycle and stays stable until the next FETCH.
- WAIT_BUSY: wait for tx_finish==0, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_finish==1.
  - If word<WORDS_PER_COLUMN-1: word++, then FETCH.
  - Otherwise: word=0 and load the hold counter with the latched cfg_hold, then HOLD.
- HOLD: decrement the counter each cycle. Leave when the counter is 0; a hold of 0 leaves after 1 cycle.
  - If col<COLUMNS-1: col++, then FETCH.
  - Otherwise: FRAME_END.
- FRAME_END: frame_done=1 for one cycle, busy drops, return to IDLE. A back-to-back frame may start in the following cycle.
- Latency: first command pulse occurs 2 cycles after the start condition is sampled in IDLE.
- Commands are mutually exclusive. Never more than one command in flight.
- enable or frame_valid deasserting mid-frame has no effect; the frame always completes.
- cfg_* changes mid-frame are ignored.
- rd_addr increments linearly 0..COLUMNS*WORDS_PER_COLUMN-1 and wraps to 0 at the next frame.
- WORDS_PER_COLUMN=1: no next_data is ever issued.
- COLUMNS=1: no start_next_column is ever issued.

Decomposition:
- Package matrix_ctrl_pkg holds:
  - the scan state_t enum;
  - a command-kind enum (CMD_FIRST, CMD_NEXT, CMD_DATA);
  - localparam helpers for address width.
- One natural sub-module, scan_hold_timer: loadable down-counter with a done flag, HOLD_W wide.

Test Plan:
- Reset then enable=1, frame_valid=1, COLUMNS=2, WORDS=2, cfg_hold=0, output_module model busy for 5 cycles per command:
  - rd_addr sequence 0,1,2,3;
  - command order start_first_column, next_data, start_next_column, next_data;
  - frame_done exactly once.
- Hold timing with cfg_hold=10: gap from the last tx_finish rise of column 0 to column 1's FETCH is 11 cycles; frame_done lands 11 cycles after the final tx_finish rise.
- Back-to-back frames with frame_valid held high: second frame's start_first_column occurs 3 cycles after frame_done, and rd_addr restarts at 0.
- Drop enable and frame_valid mid-frame: frame still completes and frame_done pulses; no new frame starts while enable=0.
- Assert rst during WAIT_DONE: all outputs 0 in the same cycle; after release nothing is issued until the start condition recurs.
- Change cfg_extra_bit and cfg_hold mid-frame: extra_bit and hold durations keep their frame-start values until the next frame.
